// File: rtl/wb_sd_block_ram.sv
// Wishbone B4 registered-feedback slave memory used as the SD emulator's
// block store. Supports byte-lane writes, incrementing and wrapping bursts,
// out-of-range error termination and a write-protect input.
module wb_sd_block_ram #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 512,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic [2:0]                wb_cti_i,
    input  logic [1:0]                wb_bte_i,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    input  logic                      i_wp
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(SEL_W);
    localparam int MW    = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SINGLE = 2'd1;
    localparam logic [1:0] ST_BURST  = 2'd2;

    localparam logic [2:0] CTI_INCR  = 3'b010;

    // Next word index of a burst: linear steps by one, wrapN only rolls the
    // low log2(N) bits so the beat stays inside its aligned N-word block.
    function automatic logic [ADDR_WIDTH-1:0] next_index(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [1:0]            bte
    );
        logic [ADDR_WIDTH-1:0] nxt;
        nxt = idx;
        case (bte)
            2'b00:   nxt = idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            2'b01:   nxt = {idx[ADDR_WIDTH-1:2], idx[1:0] + 2'd1};
            2'b10:   nxt = {idx[ADDR_WIDTH-1:3], idx[2:0] + 3'd1};
            2'b11:   nxt = {idx[ADDR_WIDTH-1:4], idx[3:0] + 4'd1};
            default: nxt = idx;
        endcase
        return nxt;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [1:0]            state_r;
    logic [ADDR_WIDTH-1:0] idx_r;
    logic [1:0]            bte_r;
    logic                  ack_r;
    logic                  err_r;
    logic [DATA_WIDTH-1:0] dat_r;

    logic                  cyc_stb_s;
    logic [ADDR_WIDTH-1:0] start_idx_s;
    logic [ADDR_WIDTH-1:0] pred_idx_s;
    logic                  issue_s;
    logic                  first_s;
    logic                  bad_s;
    logic [ADDR_WIDTH-1:0] issue_idx_s;
    logic [1:0]            path_state_s;
    logic [1:0]            next_state_s;

    assign cyc_stb_s   = wb_cyc_i & wb_stb_i;
    // Subtracting the base first makes addresses below it wrap to huge
    // indices, so the single range check also rejects them.
    assign start_idx_s = (wb_adr_i - BASE_ADDR) >> SHIFT;
    assign pred_idx_s  = next_index(idx_r, bte_r);

    // Decide whether a beat is issued this edge, from which index, and where the FSM goes.
    always_comb begin
        path_state_s = state_r;
        issue_s      = 1'b0;
        first_s      = 1'b0;
        issue_idx_s  = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (cyc_stb_s) begin
                    issue_s      = 1'b1;
                    first_s      = 1'b1;
                    issue_idx_s  = start_idx_s;
                    path_state_s = (wb_cti_i == CTI_INCR) ? ST_BURST : ST_SINGLE;
                end else begin
                    path_state_s = ST_IDLE;
                end
            end
            ST_SINGLE: begin
                path_state_s = ST_IDLE;
            end
            ST_BURST: begin
                if (cyc_stb_s && (wb_cti_i == CTI_INCR)) begin
                    issue_s      = 1'b1;
                    issue_idx_s  = pred_idx_s;
                    path_state_s = ST_BURST;
                end else begin
                    path_state_s = ST_IDLE;
                end
            end
            default: begin
                path_state_s = ST_IDLE;
            end
        endcase
        bad_s = issue_s && ((issue_idx_s >= DEPTH_A) || (wb_we_i && i_wp));
    end

    // An erroring beat always finishes through SINGLE so the bus sees one err cycle then idle.
    assign next_state_s = bad_s ? ST_SINGLE : path_state_s;

    // Control registers and registered bus outputs.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            bte_r   <= 2'b00;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            dat_r   <= '0;
        end else begin
            state_r <= next_state_s;
            ack_r   <= issue_s & ~bad_s;
            err_r   <= bad_s;
            if (issue_s) begin
                idx_r <= issue_idx_s;
            end
            if (first_s) begin
                bte_r <= wb_bte_i;
            end
            if (issue_s && !bad_s) begin
                dat_r <= mem[issue_idx_s[MW-1:0]];
            end
        end
    end

    // Byte-lane write commit at the edge closing an acked write beat.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_n_i && ack_r && wb_we_i) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (wb_sel_i[b]) begin
                    mem[idx_r[MW-1:0]][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
                end
            end
        end
    end

    assign wb_ack_o = ack_r;
    assign wb_err_o = err_r;
    assign wb_dat_o = dat_r;

endmodule

// File: tb/tb_wb_sd_block_ram.sv
// Directed testbench for wb_sd_block_ram with a transaction-level memory
// model and a single per-cycle compare process on the falling clock edge.
module tb_wb_sd_block_ram;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we, wp;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] rdat;
    logic        ack, err;

    wb_sd_block_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(rdat), .wb_ack_o(ack),
        .wb_err_o(err), .i_wp(wp)
    );

    always #5 clk = ~clk;

    // model state
    logic [31:0] mdl [DEPTH];
    logic [31:0] m_dat;
    logic        m_known;
    logic        exp_ack, exp_err, exp_chk, chk_en;
    logic [31:0] exp_dat;
    logic [31:0] seen_q [$];
    int          seen_ack, seen_err;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] got;

    // per-cycle comparison of DUT outputs against the model expectation
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (ack !== exp_ack) begin
                n_bad++;
                $display("FAIL ack_cycle t=%0t got %b want %b", $time, ack, exp_ack);
            end
            n_cmp++;
            if (err !== exp_err) begin
                n_bad++;
                $display("FAIL err_cycle t=%0t got %b want %b", $time, err, exp_err);
            end
            if (exp_chk) begin
                n_cmp++;
                if (rdat !== exp_dat) begin
                    n_bad++;
                    $display("FAIL dat_cycle t=%0t got %h want %h", $time, rdat, exp_dat);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expectation for the outputs of the current cycle
    task automatic set_exp(input logic a, input logic e, input logic rd, input logic [31:0] d);
        exp_ack = a;
        exp_err = e;
        if (rd) begin
            m_dat   = d;
            m_known = 1'b1;
        end else if (a || e) begin
            m_known = 1'b0;
        end
        exp_chk = m_known;
        exp_dat = m_dat;
        if (a) begin
            seen_ack++;
            if (rd) seen_q.push_back(rdat);
        end
        if (e) seen_err++;
    endtask

    task automatic exp_reset();
        exp_ack = 1'b0;
        exp_err = 1'b0;
        m_dat   = 32'h0;
        m_known = 1'b1;
        exp_chk = 1'b1;
        exp_dat = 32'h0;
    endtask

    task automatic idle_cycle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 32'h0);
        step();
    endtask

    // classic single access: request cycle, then one termination cycle
    task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic p, output logic [31:0] rd_val);
        int   i;
        logic bad;
        i   = int'(a >> 2);
        bad = (i >= DEPTH) || (w && p);
        cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d; sel = s; wp = p;
        cti = 3'b000; bte = 2'b00;
        set_exp(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        rd_val = rdat;
        if (bad)    set_exp(1'b0, 1'b1, 1'b0, 32'h0);
        else if (w) set_exp(1'b1, 1'b0, 1'b0, 32'h0);
        else        set_exp(1'b1, 1'b0, 1'b1, mdl[i]);
        step();
        if (!bad && w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[i][b*8 +: 8] = d[b*8 +: 8];
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wp = 1'b0;
    endtask

    // read burst of n beats; beat indices follow the burst-type arithmetic
    task automatic burst(input int start, input int n, input logic [1:0] bt);
        int idx, nn;
        idx = start;
        nn  = (bt == 2'b00) ? 0 : (bt == 2'b01) ? 4 : (bt == 2'b10) ? 8 : 16;
        seen_q.delete();
        seen_ack = 0;
        seen_err = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; wp = 1'b0; sel = 4'hF;
        adr = 32'(start) << 2; bte = bt;
        cti = (n == 1) ? 3'b111 : 3'b010;
        set_exp(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        for (int k = 0; k < n; k++) begin
            cti = (k == n - 1) ? 3'b111 : 3'b010;
            adr = 32'h0000_0FF0;  // must not be resampled mid-burst
            if (idx >= DEPTH) begin
                set_exp(1'b0, 1'b1, 1'b0, 32'h0);
                step();
                break;
            end
            set_exp(1'b1, 1'b0, 1'b1, mdl[idx]);
            step();
            idx = (nn == 0) ? idx + 1 : (idx - idx % nn) + ((idx % nn) + 1) % nn;
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    logic [31:0] lin_exp  [4];
    logic [31:0] wrap_exp [4];

    initial begin
        lin_exp  = '{32'h102, 32'h103, 32'h104, 32'h105};
        wrap_exp = '{32'h106, 32'h107, 32'h104, 32'h105};
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        chk_en = 1'b0; m_known = 1'b0; m_dat = 32'h0;
        exp_ack = 1'b0; exp_err = 1'b0; exp_chk = 1'b0; exp_dat = 32'h0;
        seen_ack = 0; seen_err = 0;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; wp = 1'b0;
        adr = 32'h0; wdat = 32'h0; sel = 4'h0; cti = 3'b000; bte = 2'b00;

        // reset
        step();
        exp_reset();
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;
        idle_cycle();

        // byte-lane writes then readback
        classic(32'h10, 1'b1, 32'hAABBCCDD, 4'b1111, 1'b0, got);
        classic(32'h10, 1'b1, 32'h11223344, 4'b0011, 1'b0, got);
        classic(32'h10, 1'b0, 32'h0, 4'b1111, 1'b0, got);
        chk("byte_lane_read", got, 32'hAABB3344);

        // sel=0 write is acked but changes nothing
        classic(32'h10, 1'b1, 32'hFFFFFFFF, 4'b0000, 1'b0, got);
        classic(32'h10, 1'b0, 32'h0, 4'b1111, 1'b0, got);
        chk("sel_zero_read", got, 32'hAABB3344);

        // write-protected write errors and leaves memory intact
        seen_err = 0;
        classic(32'h10, 1'b1, 32'h0BAD0BAD, 4'b1111, 1'b1, got);
        chk("wp_err_count", 32'(seen_err), 32'd1);
        classic(32'h10, 1'b0, 32'h0, 4'b1111, 1'b0, got);
        chk("wp_readback", got, 32'hAABB3344);

        // preload words 0..7 and the two top words
        for (int i = 0; i < 8; i++)
            classic(32'(i) << 2, 1'b1, 32'h100 + 32'(i), 4'b1111, 1'b0, got);
        classic(32'(DEPTH - 2) << 2, 1'b1, 32'hCAFE01FE, 4'b1111, 1'b0, got);
        classic(32'(DEPTH - 1) << 2, 1'b1, 32'hCAFE01FF, 4'b1111, 1'b0, got);
        idle_cycle();

        // linear burst from byte address 0x8
        burst(2, 4, 2'b00);
        idle_cycle();
        chk("lin_beats", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            chk($sformatf("lin_beat%0d", i), seen_q[i], lin_exp[i]);

        // wrap4 burst from word 6
        burst(6, 4, 2'b01);
        idle_cycle();
        chk("wrap4_beats", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            chk($sformatf("wrap4_beat%0d", i), seen_q[i], wrap_exp[i]);

        // wrap8 burst from word 5 crosses the block boundary back to word 0
        burst(5, 5, 2'b10);
        idle_cycle();
        chk("wrap8_beats", 32'(seen_q.size()), 32'd5);
        if (seen_q.size() == 5) chk("wrap8_beat3", seen_q[3], 32'h100);

        // out-of-range classic read
        seen_err = 0;
        classic(32'(DEPTH) << 2, 1'b0, 32'h0, 4'b1111, 1'b0, got);
        chk("oor_err_count", 32'(seen_err), 32'd1);
        idle_cycle();

        // burst running off the end of the memory
        burst(DEPTH - 2, 4, 2'b00);
        idle_cycle();
        chk("eor_acks", 32'(seen_ack), 32'd2);
        chk("eor_errs", 32'(seen_err), 32'd1);
        if (seen_q.size() == 2) chk("eor_beat1", seen_q[1], 32'hCAFE01FF);

        // reset asserted during beat 2 of a burst
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; bte = 2'b00; cti = 3'b010;
        set_exp(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        set_exp(1'b1, 1'b0, 1'b1, mdl[0]);
        step();
        rst_n = 1'b0;
        set_exp(1'b1, 1'b0, 1'b1, mdl[1]);
        step();
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;
        exp_reset();
        step();
        idle_cycle();
        classic(32'hC, 1'b0, 32'h0, 4'b1111, 1'b0, got);
        chk("post_reset_read", got, 32'h103);
        classic(32'h1C, 1'b0, 32'h0, 4'b1111, 1'b0, got);
        chk("post_reset_read2", got, 32'h107);
        idle_cycle();
        idle_cycle();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
